mod_updown_counter: RTL



---
 rtl/mod_updown_counter_pkg.sv | 15 +
 rtl/mod_updown_counter_if.sv | 27 ++
 rtl/mod_updown_counter_tick_prescaler.sv | 30 +++
 rtl/mod_updown_counter.sv | 81 ++++++++
 4 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package mod_updown_counter_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  // Prescaler counter width: ceil(log2(presc)), never narrower than one bit.
  function automatic int prescale_width(input int presc);
    int w;
    w = 0;
    while ((1 << w) < presc) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control and status bundle of the up/down counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 8
);
  // No handshake: the controls are level signals sampled on every rising
  // clk edge, and the status signals are registered outputs of the counter.
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             ovf;
  logic             step;

  modport master (
    output en, up, load, load_value, clear,
    input  out, tc, ovf, step
  );

  modport slave (
    input  en, up, load, load_value, clear,
    output out, tc, ovf, step
  );

endinterface

// File: rtl/mod_updown_counter_tick_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
module tick_prescaler
  import mod_updown_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // A load or clear in the same cycle suppresses the step entirely.
  assign step = en && !sync_clr && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || sync_clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= step ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with modulus, wrap/saturate mode, prescaler,
// terminal-count pulse and sticky overflow flag.
module mod_updown_counter
  import mod_updown_counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
  parameter bit               SATURATE  = MODE_WRAP,
  parameter int               PRESCALE  = 1
) (
  input logic                 clk,
  input logic                 reset,
  mod_updown_counter_if.slave bus
);

  logic             strobe;
  logic             at_bound;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             tc_q;
  logic             ovf_q;
  logic             step_q;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (bus.en),
    .sync_clr (bus.clear | bus.load),
    .step     (strobe)
  );

  // Boundary depends on the direction in force at the step.
  assign at_bound     = bus.up ? (cnt_q == MAX_VALUE) : (cnt_q == '0);
  assign load_clamped = (bus.load_value > MAX_VALUE) ? MAX_VALUE : bus.load_value;

  always_comb begin
    cnt_d = cnt_q;
    if (at_bound) begin
      if (SATURATE == MODE_WRAP) begin
        cnt_d = bus.up ? '0 : MAX_VALUE;
      end
    end else begin
      cnt_d = bus.up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      step_q <= 1'b0;
    end else if (bus.clear) begin
      cnt_q  <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      step_q <= 1'b0;
    end else if (bus.load) begin
      cnt_q  <= load_clamped;
      tc_q   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= strobe;
      // A blocked step in saturate mode is still a boundary event.
      tc_q   <= strobe && at_bound;
      if (strobe) begin
        cnt_q <= cnt_d;
        if (at_bound) ovf_q <= 1'b1;
      end
    end
  end

  assign bus.out  = cnt_q;
  assign bus.tc   = tc_q;
  assign bus.ovf  = ovf_q;
  assign bus.step = step_q;

endmodule
